// File: rtl/serial_add_sub.sv
// Bit-serial adder/subtractor: one result bit per clock, LSB first.
// Operands are captured on start; result/cout update once per operation.
module serial_add_sub #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic             control,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             cout
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  localparam int CW = $clog2(WIDTH) + 1;

  logic [1:0]       state;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] sum;
  logic             carry;
  logic [CW-1:0]    cnt;

  logic             s;
  logic             c_nxt;
  logic             last;
  logic [WIDTH-1:0] sum_nxt;

  assign s       = a[0] ^ b[0] ^ carry;
  assign c_nxt   = (a[0] & b[0]) | (a[0] & carry) | (b[0] & carry);
  assign last    = (cnt == CW'(WIDTH - 1));
  assign sum_nxt = {s, sum[WIDTH-1:1]};

  assign busy = (state != IDLE);
  assign done = (state == DONE);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= IDLE;
      a      <= '0;
      b      <= '0;
      sum    <= '0;
      carry  <= 1'b0;
      cnt    <= '0;
      result <= '0;
      cout   <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            // Subtraction as x + ~y + 1
            state <= RUN;
            a     <= x;
            b     <= y ^ {WIDTH{control}};
            carry <= control;
            cnt   <= '0;
            sum   <= '0;
          end
        end
        RUN: begin
          a     <= a >> 1;
          b     <= b >> 1;
          sum   <= sum_nxt;
          carry <= c_nxt;
          cnt   <= cnt + CW'(1);
          if (last) begin
            // Final bit goes straight into the result
            state  <= DONE;
            result <= sum_nxt;
            cout   <= c_nxt;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
